pwm_level_ramp_ctrl: RTL and testbench

Sequences the 8-bit duty level fed to the fixed-frequency heater PWM generator. It accepts a target duty over a valid/ready handshake and ramps the level toward it in bounded steps, one step per PWM period. An over-temperature fault input forces the level to zero immediately and latches until cleared. Sits between the temperature control loop and the PWM generator's level input.

---
 rtl/pwm_level_ramp_ctrl.sv | 130 +++++++++++++
 tb/tb_pwm_level_ramp_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_level_ramp_ctrl.sv
// Heater PWM duty sequencer: accepts a target duty and ramps the level toward it
// in bounded steps per PWM period; fault forces zero. Optional watchdog: RAMP_WDOG_EN.
module pwm_level_ramp_ctrl #(
  parameter int unsigned PERIOD       = 255,
  parameter int unsigned STEP         = 4,
  parameter int unsigned STEP_PERIODS = 1
`ifdef RAMP_WDOG_EN
  , parameter int unsigned WDOG_PERIODS = 1024
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic       fault,
  input  logic       fault_clear,
  output logic [7:0] level,
  output logic       period_tick,
  output logic       busy,
  output logic       at_target,
  output logic       wdog_expired
);

  typedef enum logic [1:0] {IDLE, RAMP, FAULT} state_t;

  localparam logic [15:0] PCNT_LAST = 16'(PERIOD - 1);
  localparam logic [7:0]  SCNT_LAST = 8'(STEP_PERIODS - 1);
  localparam logic [8:0]  STEP9     = 9'(STEP);

  state_t      state, state_nxt;
  logic [15:0] pcnt;
  logic [7:0]  scnt;
  logic [7:0]  tgt_reg, tgt_nxt, level_nxt, stepped;
  logic [8:0]  up9, dn9;
  logic        step_event, accept, wdog_trip;

  assign step_event   = period_tick && (scnt == SCNT_LAST);
  assign accept       = target_valid && (state != FAULT) && !fault;
  assign target_ready = (state != FAULT);
  assign busy         = (state == RAMP);
  assign at_target    = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt        <= '0;
      scnt        <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= (pcnt == PCNT_LAST);
      if (pcnt == PCNT_LAST) pcnt <= '0;
      else                   pcnt <= pcnt + 16'd1;
      if (step_event)       scnt <= '0;
      else if (period_tick) scnt <= scnt + 8'd1;
    end
  end

  // 9-bit step arithmetic: clamp to the target, never wrap past 255 or below 0
  always_comb begin
    up9     = {1'b0, level} + STEP9;
    dn9     = {1'b0, level} - STEP9;
    stepped = level;
    if (level < tgt_reg) begin
      stepped = (up9 >= {1'b0, tgt_reg}) ? tgt_reg : up9[7:0];
    end else if (level > tgt_reg) begin
      stepped = (({1'b0, level} < STEP9) || (dn9 <= {1'b0, tgt_reg})) ? tgt_reg : dn9[7:0];
    end
  end

`ifdef RAMP_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_PERIODS - 1);
  logic [15:0] wdog_cnt;

  assign wdog_trip = period_tick && (wdog_cnt == WDOG_LAST) && (state != FAULT) && !fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt     <= '0;
      wdog_expired <= 1'b0;
    end else begin
      if (fault || (state == FAULT) || accept || wdog_trip) wdog_cnt <= '0;
      else if (period_tick)                                 wdog_cnt <= wdog_cnt + 16'd1;
      if (accept)         wdog_expired <= 1'b0;
      else if (wdog_trip) wdog_expired <= 1'b1;
    end
  end
`else
  assign wdog_trip    = 1'b0;
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      level   <= '0;
      tgt_reg <= '0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      tgt_reg <= tgt_nxt;
    end
  end

  // The step lands first (old target); a same-edge accept then picks direction from the new level
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    tgt_nxt   = tgt_reg;
    if (fault) begin
      state_nxt = FAULT;
      level_nxt = '0;
      tgt_nxt   = '0;
    end else if (state == FAULT) begin
      if (fault_clear) state_nxt = IDLE;
    end else begin
      if ((state == RAMP) && step_event) begin
        level_nxt = stepped;
        if (stepped == tgt_reg) state_nxt = IDLE;
      end
      if (accept) begin
        tgt_nxt   = target;
        state_nxt = (target != level_nxt) ? RAMP : IDLE;
      end else if (wdog_trip) begin
        tgt_nxt   = '0;
        state_nxt = (level_nxt == '0) ? IDLE : RAMP;
      end
    end
  end

endmodule

// File: tb/tb_pwm_level_ramp_ctrl.sv
// Self-checking bench for pwm_level_ramp_ctrl: directed scenarios plus random
// traffic, all outputs compared every cycle against an arithmetic reference model.
module tb_pwm_level_ramp_ctrl;

  localparam int P  = 8;
  localparam int S  = 4;
  localparam int SP = 1;
  localparam int W  = 80;
`ifdef RAMP_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] target = '0;
  logic       target_valid = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clear = 1'b0;
  logic       target_ready, period_tick, busy, at_target, wdog_expired;
  logic [7:0] level;

  int n_cmp = 0;
  int n_err = 0;

  pwm_level_ramp_ctrl #(
    .PERIOD(P),
    .STEP(S),
    .STEP_PERIODS(SP)
`ifdef RAMP_WDOG_EN
    , .WDOG_PERIODS(W)
`endif
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .target(target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .fault(fault),
    .fault_clear(fault_clear),
    .level(level),
    .period_tick(period_tick),
    .busy(busy),
    .at_target(at_target),
    .wdog_expired(wdog_expired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_mode 0=holding at target, 1=ramping, 2=faulted
  int m_level, m_tgt, m_mode, m_edges, m_ticks, m_wcnt;
  bit m_tick, m_wexp, m_stp, m_acc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_level = 0; m_tgt = 0; m_mode = 0; m_edges = 0; m_ticks = 0;
      m_wcnt = 0; m_tick = 0; m_wexp = 0;
    end else begin
      m_stp = 0;
      if (m_tick) begin
        m_ticks++;
        m_stp = (m_ticks % SP) == 0;
      end
      m_acc = target_valid && (m_mode != 2);
      if (fault) begin
        m_level = 0; m_tgt = 0; m_mode = 2; m_wcnt = 0;
      end else if (m_mode == 2) begin
        if (fault_clear) m_mode = 0;
      end else begin
        if (m_mode == 1 && m_stp) begin
          if (m_tgt > m_level) m_level = (m_level + S < m_tgt) ? m_level + S : m_tgt;
          else                 m_level = (m_level - S > m_tgt) ? m_level - S : m_tgt;
          if (m_level == m_tgt) m_mode = 0;
        end
        if (m_acc) begin
          m_tgt = int'(target);
          m_mode = (m_tgt != m_level) ? 1 : 0;
          m_wexp = 0; m_wcnt = 0;
        end else if (WD_EN && m_tick) begin
          m_wcnt++;
          if (m_wcnt == W) begin
            m_tgt = 0; m_mode = (m_level == 0) ? 0 : 1; m_wexp = 1; m_wcnt = 0;
          end
        end
      end
      m_edges++;
      m_tick = (m_edges % P) == 0;
    end
  end

  always @(negedge clock) begin
    check("level", {8'd0, level}, 16'(m_level));
    check("busy", {15'd0, busy}, {15'd0, m_mode == 1});
    check("at_target", {15'd0, at_target}, {15'd0, m_mode == 0});
    check("target_ready", {15'd0, target_ready}, {15'd0, m_mode != 2});
    check("period_tick", {15'd0, period_tick}, {15'd0, m_tick});
    check("wdog_expired", {15'd0, wdog_expired}, {15'd0, m_wexp});
  end

  task automatic send(input logic [7:0] t);
    target = t;
    target_valid = 1'b1;
    @(negedge clock);
    target_valid = 1'b0;
  endtask

  task automatic expect_next(input string tag, input logic [7:0] e);
    logic [7:0] prev;
    prev = level;
    for (int i = 0; i < 4 * P && level == prev; i++) @(negedge clock);
    check(tag, {8'd0, level}, {8'd0, e});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && at_target !== 1'b1; i++) @(negedge clock);
    check(tag, {15'd0, at_target}, 16'd1);
  endtask

  task automatic wait_level(input string tag, input logic [7:0] e);
    for (int i = 0; i < 100 * P && level !== e; i++) @(negedge clock);
    check(tag, {8'd0, level}, {8'd0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_level", {8'd0, level}, 16'd0);
    check("rst_at_target", {15'd0, at_target}, 16'd1);
    check("rst_ready", {15'd0, target_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    send(8'd10);
    check("s1_busy", {15'd0, busy}, 16'd1);
    expect_next("s1_l4", 8'd4);
    expect_next("s1_l8", 8'd8);
    expect_next("s1_l10", 8'd10);
    wait_idle("s1_done", 4 * P);
    check("s1_busy_end", {15'd0, busy}, 16'd0);

    send(8'd3);
    expect_next("s2_l6", 8'd6);
    expect_next("s2_l3", 8'd3);
    wait_idle("s2_done", 4 * P);
    send(8'd2);
    expect_next("s2_l2", 8'd2);
    wait_idle("s2b_done", 4 * P);
    send(8'd0);
    expect_next("s2_l0", 8'd0);
    wait_idle("s2c_done", 4 * P);

    send(8'd255);
    for (int k = 1; k <= 64; k++) expect_next("s3_up", 8'((4 * k > 255) ? 255 : 4 * k));
    wait_idle("s3_up_done", 4 * P);
    send(8'd0);
    for (int k = 1; k <= 64; k++) expect_next("s3_dn", 8'((255 - 4 * k < 0) ? 0 : 255 - 4 * k));
    wait_idle("s3_dn_done", 4 * P);

    send(8'd200);
    wait_level("s3_at40", 8'd40);
    send(8'd100);
    wait_idle("s3_retarget_done", 40 * P);
    check("s3_l100", {8'd0, level}, 16'd100);

    send(8'd0);
    wait_idle("s4_zero", 40 * P);
    send(8'd20);
    wait_level("s4_at8", 8'd8);
    for (int i = 0; i < 2 * P && period_tick !== 1'b1; i++) @(negedge clock);
    send(8'd0);
    check("s4_coinc_l12", {8'd0, level}, 16'd12);
    expect_next("s4_l8", 8'd8);
    expect_next("s4_l4", 8'd4);
    expect_next("s4_l0", 8'd0);
    wait_idle("s4_done", 4 * P);

    send(8'd40);
    wait_level("s5_at20", 8'd20);
    fault = 1'b1;
    @(negedge clock);
    check("s5_fault_level", {8'd0, level}, 16'd0);
    check("s5_fault_ready", {15'd0, target_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      target = 8'd77; target_valid = 1'b1; fault_clear = 1'b1;
      @(negedge clock);
    end
    target_valid = 1'b0;
    check("s5_hold_ready", {15'd0, target_ready}, 16'd0);
    check("s5_hold_level", {8'd0, level}, 16'd0);
    fault = 1'b0;
    @(negedge clock);
    fault_clear = 1'b0;
    check("s5_clr_ready", {15'd0, target_ready}, 16'd1);
    check("s5_clr_idle", {15'd0, at_target}, 16'd1);
    check("s5_clr_level", {8'd0, level}, 16'd0);

`ifdef RAMP_WDOG_EN
    send(8'd12);
    wait_idle("s6_at12", 10 * P);
    for (int i = 0; i < (W + 4) * P && wdog_expired !== 1'b1; i++) @(negedge clock);
    check("s6_wdog_set", {15'd0, wdog_expired}, 16'd1);
    expect_next("s6_l8", 8'd8);
    expect_next("s6_l4", 8'd4);
    expect_next("s6_l0", 8'd0);
    send(8'd5);
    check("s6_wdog_clr", {15'd0, wdog_expired}, 16'd0);
`endif

    for (int c = 0; c < 4000; c++) begin
      case ($urandom % 4)
        0:       target = 8'd0;
        1:       target = 8'd255;
        default: target = 8'($urandom);
      endcase
      target_valid = ($urandom % 6) == 0;
      fault = (($urandom % 300) == 0) || (fault && ($urandom % 4) != 0);
      fault_clear = ($urandom % 8) == 0;
      @(negedge clock);
    end
    target_valid = 1'b0; fault = 1'b0; fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
